pattern_gen: RTL and testbench
==============================

# pattern_gen

Pixel-rate test-pattern generator that sits directly downstream of the horizontal/vertical timing generators on the 480x272 LCD path. It consumes sync, data-enable and pixel coordinates, selects one of eight patterns, and drives RGB565 with sync and DE delayed to match. The active pattern changes only at frame boundaries. A frame counter provides animation and a debug output.

## Interface
Parameters:
- HACTIVE, 480, visible pixels per line
- VACTIVE, 272, visible lines per frame

Ports:
- i_clk  in  1  pixel clock; all inputs are synchronous to it
- i_rst  in  1  asynchronous, active-high reset
- i_hsync  in  1  horizontal sync, active low
- i_vsync  in  1  vertical sync, active low
- i_hde  in  1  horizontal data enable
- i_vde  in  1  vertical data enable
- i_x  in  9  pixel column, valid while i_hde=1
- i_y  in  9  pixel row, valid while i_vde=1
- i_next  in  1  one-cycle pulse that advances the pattern selection
- o_hsync  out  1  i_hsync delayed 2 cycles
- o_vsync  out  1  i_vsync delayed 2 cycles
- o_de  out  1  (i_hde & i_vde) delayed 2 cycles
- o_r  out  5  red
- o_g  out  6  green
- o_b  out  5  blue
- o_pattern  out  3  currently active pattern
- o_frame  out  8  frame counter

## Operation
- Frame start (fs): one-cycle event on the i_vsync 1→0 edge, detected against a registered copy of i_vsync. The registered copy resets to 1.
- Pattern select:
  - pending (3 bit) increments mod 8 on each i_next pulse.
  - active (3 bit) loads pending on fs.
  - If i_next and fs occur in the same cycle, active loads the pre-increment pending value. The new value takes effect at the next fs.
- On each fs:
  - frame increments and wraps 255→0.
  - pos (9 bit) becomes pos+2. If pos+2 ≥ HACTIVE, pos becomes 0 instead.
- Colour per active pattern. Colours are full-scale: white=(31,63,31), black=(0,0,0).
  - 0, colour bars, 60 px wide: x<60 white, <120 yellow, <180 cyan, <240 green, <300 magenta, <360 red, <420 blue, else black. Bars are decoded with a comparator chain, not a divider.
  - 1, checkerboard: white if x[4]^y[4], else black.
  - 2, horizontal ramp: r=x[8:4], g=x[8:3], b=x[8:4].
  - 3, vertical ramp: r=y[8:4], g=y[8:3], b=y[8:4].
  - 4, moving bar: white if pos ≤ x < pos+16, else blue (0,0,31).
  - 5, grid: white if x[4:0]==0, y[4:0]==0, x==HACTIVE-1 or y==VACTIVE-1; else black.
  - 6, solid white.
  - 7, solid red (31,0,0).
- When the delayed DE is 0, RGB is forced to 0.
- Pattern, frame and pos used for a pixel are the values registered at the time that pixel enters stage 1.
- Reset values:
  - o_hsync=1, o_vsync=1, o_de=0, RGB=0.
  - pending=0, active=0, o_pattern=0.
  - frame=0, pos=0.
  - All pipeline registers are cleared to the same values.

## Timing
- Pipeline, 2 stages:
  - Stage 1 registers the syncs and DE, and computes bar index, checker, grid and bar-window flags.
  - Stage 2 registers the final colour.
- Latency is exactly 2 cycles from inputs to every output. A pixel (x,y) presented at cycle n appears at cycle n+2, aligned with its o_de.
- fs affects the pixel presented in the cycle after the fs cycle and all later pixels. No pixel in the active area may be affected, because vsync lies in blanking.
- o_pattern and o_frame update 1 cycle after fs.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - After deassertion, output stays blank until a new DE arrives.
  - The first fs after reset sets frame=1 and pos=2.
- i_next pulses held longer than 1 cycle count once per cycle (no edge detect).

## Test plan
- Reset: assert i_rst mid-line → o_de=0, o_hsync=o_vsync=1, RGB=0, o_frame=0, o_pattern=0 immediately. Release and run one frame → o_frame=1.
- Colour bars: pattern 0, line y=10, x=0,59,60,239,240,479 → white, white, yellow, green, magenta, black at cycles n+2. o_de and RGB aligned.
- Pattern switch:
  - Pulse i_next mid-frame → o_pattern stays 0 until 1 cycle after the next i_vsync fall, then becomes 1.
  - First active pixel of that frame at (0,0) → black. Pixel (16,0) → white.
- Simultaneous event: pending=1, i_next pulse on the fs cycle → o_pattern=1. After the following fs → o_pattern=2.
- Moving bar:
  - After 239 frames from reset → pos=478.
  - Next fs → pos=0.
  - In pattern 4 at pos=0: x=15 white, x=16 blue.
- Blanking/grid: pattern 5 → (0,5) white, (5,5) black, (479,100) white, (100,271) white. Every cycle with o_de=0 → RGB=0.

Source files
------------

// File: rtl/pattern_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pattern_gen_if
// Brief    : Video timing input and RGB565 pixel output bundle for pattern_gen
// Revision : 1.0
// ----------------------------------------------------------------------------
interface pattern_gen_if;
  logic       i_hsync;
  logic       i_vsync;
  logic       i_hde;
  logic       i_vde;
  logic [8:0] i_x;
  logic [8:0] i_y;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_de;
  logic [4:0] o_r;
  logic [5:0] o_g;
  logic [4:0] o_b;

  modport master (
    output i_hsync, i_vsync, i_hde, i_vde, i_x, i_y,
    input  o_hsync, o_vsync, o_de, o_r, o_g, o_b
  );

  modport slave (
    input  i_hsync, i_vsync, i_hde, i_vde, i_x, i_y,
    output o_hsync, o_vsync, o_de, o_r, o_g, o_b
  );
endinterface
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pattern_gen
// Brief    : Two-stage RGB565 test-pattern generator, eight frame-synchronous
//            patterns with frame counter and moving-bar animation
// Revision : 1.0
// ----------------------------------------------------------------------------
module pattern_gen #(
  parameter int HACTIVE = 480,
  parameter int VACTIVE = 272
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_next,
  pattern_gen_if.slave  bus,
  output logic [2:0]    o_pattern,
  output logic [7:0]    o_frame
);

  localparam logic [9:0] c_hactive = 10'(HACTIVE);
  localparam logic [9:0] c_hlast   = 10'(HACTIVE - 1);
  localparam logic [9:0] c_vlast   = 10'(VACTIVE - 1);
  localparam logic [15:0] c_white   = {5'd31, 6'd63, 5'd31};
  localparam logic [15:0] c_yellow  = {5'd31, 6'd63, 5'd0};
  localparam logic [15:0] c_cyan    = {5'd0,  6'd63, 5'd31};
  localparam logic [15:0] c_green   = {5'd0,  6'd63, 5'd0};
  localparam logic [15:0] c_magenta = {5'd31, 6'd0,  5'd31};
  localparam logic [15:0] c_red     = {5'd31, 6'd0,  5'd0};
  localparam logic [15:0] c_blue    = {5'd0,  6'd0,  5'd31};
  localparam logic [15:0] c_black   = 16'd0;

  logic       r_vsync_q;
  logic [2:0] r_pending;
  logic [2:0] r_active;
  logic [7:0] r_frame;
  logic [8:0] r_pos;

  logic       r_s1_hsync, r_s1_vsync, r_s1_de;
  logic [2:0] r_s1_pat;
  logic [2:0] r_s1_bar;
  logic       r_s1_chk, r_s1_grid, r_s1_win;
  logic [5:0] r_s1_xr, r_s1_yr;

  logic        r_hsync, r_vsync, r_de;
  logic [15:0] r_rgb;

  logic        w_fs;
  logic [9:0]  w_pos_sum;
  logic [8:0]  w_pos_next;
  logic [9:0]  w_x10, w_y10;
  logic [2:0]  w_bar;
  logic        w_win, w_grid;
  logic [15:0] w_rgb;

  assign w_fs       = r_vsync_q & ~bus.i_vsync;
  assign w_pos_sum  = {1'b0, r_pos} + 10'd2;
  assign w_pos_next = (w_pos_sum >= c_hactive) ? 9'd0 : w_pos_sum[8:0];
  assign w_x10      = {1'b0, bus.i_x};
  assign w_y10      = {1'b0, bus.i_y};
  assign w_win      = (w_x10 >= {1'b0, r_pos}) && (w_x10 < ({1'b0, r_pos} + 10'd16));
  assign w_grid     = (bus.i_x[4:0] == 5'd0) || (bus.i_y[4:0] == 5'd0) ||
                      (w_x10 == c_hlast) || (w_y10 == c_vlast);

  // 60-pixel colour bars decoded by threshold comparison
  always_comb begin
    w_bar = 3'd7;
    if      (bus.i_x < 9'd60)  w_bar = 3'd0;
    else if (bus.i_x < 9'd120) w_bar = 3'd1;
    else if (bus.i_x < 9'd180) w_bar = 3'd2;
    else if (bus.i_x < 9'd240) w_bar = 3'd3;
    else if (bus.i_x < 9'd300) w_bar = 3'd4;
    else if (bus.i_x < 9'd360) w_bar = 3'd5;
    else if (bus.i_x < 9'd420) w_bar = 3'd6;
  end

  always_comb begin
    w_rgb = c_black;
    case (r_s1_pat)
      3'd0: begin
        case (r_s1_bar)
          3'd0:    w_rgb = c_white;
          3'd1:    w_rgb = c_yellow;
          3'd2:    w_rgb = c_cyan;
          3'd3:    w_rgb = c_green;
          3'd4:    w_rgb = c_magenta;
          3'd5:    w_rgb = c_red;
          3'd6:    w_rgb = c_blue;
          default: w_rgb = c_black;
        endcase
      end
      3'd1:    w_rgb = r_s1_chk ? c_white : c_black;
      3'd2:    w_rgb = {r_s1_xr[5:1], r_s1_xr, r_s1_xr[5:1]};
      3'd3:    w_rgb = {r_s1_yr[5:1], r_s1_yr, r_s1_yr[5:1]};
      3'd4:    w_rgb = r_s1_win ? c_white : c_blue;
      3'd5:    w_rgb = r_s1_grid ? c_white : c_black;
      3'd6:    w_rgb = c_white;
      default: w_rgb = c_red;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vsync_q  <= 1'b1;
      r_pending  <= 3'd0;
      r_active   <= 3'd0;
      r_frame    <= 8'd0;
      r_pos      <= 9'd0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
      r_s1_de    <= 1'b0;
      r_s1_pat   <= 3'd0;
      r_s1_bar   <= 3'd0;
      r_s1_chk   <= 1'b0;
      r_s1_grid  <= 1'b0;
      r_s1_win   <= 1'b0;
      r_s1_xr    <= 6'd0;
      r_s1_yr    <= 6'd0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_de       <= 1'b0;
      r_rgb      <= 16'd0;
    end else begin
      r_vsync_q <= bus.i_vsync;
      if (i_next) r_pending <= r_pending + 3'd1;
      // Nonblocking load picks up the pre-increment pending value
      if (w_fs) begin
        r_active <= r_pending;
        r_frame  <= r_frame + 8'd1;
        r_pos    <= w_pos_next;
      end
      r_s1_hsync <= bus.i_hsync;
      r_s1_vsync <= bus.i_vsync;
      r_s1_de    <= bus.i_hde & bus.i_vde;
      r_s1_pat   <= r_active;
      r_s1_bar   <= w_bar;
      r_s1_chk   <= bus.i_x[4] ^ bus.i_y[4];
      r_s1_grid  <= w_grid;
      r_s1_win   <= w_win;
      r_s1_xr    <= bus.i_x[8:3];
      r_s1_yr    <= bus.i_y[8:3];
      r_hsync    <= r_s1_hsync;
      r_vsync    <= r_s1_vsync;
      r_de       <= r_s1_de;
      r_rgb      <= r_s1_de ? w_rgb : 16'd0;
    end
  end

  assign bus.o_hsync = r_hsync;
  assign bus.o_vsync = r_vsync;
  assign bus.o_de    = r_de;
  assign bus.o_r     = r_rgb[15:11];
  assign bus.o_g     = r_rgb[10:5];
  assign bus.o_b     = r_rgb[4:0];
  assign o_pattern   = r_active;
  assign o_frame     = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pattern_gen
// Brief    : Directed self-checking bench for pattern_gen
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pattern_gen;

  localparam logic [15:0] c_white   = {5'd31, 6'd63, 5'd31};
  localparam logic [15:0] c_yellow  = {5'd31, 6'd63, 5'd0};
  localparam logic [15:0] c_cyan    = {5'd0,  6'd63, 5'd31};
  localparam logic [15:0] c_green   = {5'd0,  6'd63, 5'd0};
  localparam logic [15:0] c_magenta = {5'd31, 6'd0,  5'd31};
  localparam logic [15:0] c_red     = {5'd31, 6'd0,  5'd0};
  localparam logic [15:0] c_blue    = {5'd0,  6'd0,  5'd31};
  localparam logic [15:0] c_black   = 16'd0;

  logic       clk;
  logic       rst;
  logic       next;
  logic [2:0] pattern;
  logic [7:0] frame;
  int         checks;
  int         failures;

  pattern_gen_if vif ();

  pattern_gen #(.HACTIVE(480), .VACTIVE(272)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_next    (next),
    .bus       (vif),
    .o_pattern (pattern),
    .o_frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb();
    return {vif.o_r, vif.o_g, vif.o_b};
  endfunction

  task automatic frame_start();
    @(negedge clk);
    vif.i_vsync = 1'b0;
    @(negedge clk);
    vif.i_vsync = 1'b1;
  endtask

  task automatic pulse_next();
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  // Present one active pixel and check it lands exactly two cycles later
  task automatic pix(input string tag, input logic [8:0] x, input logic [8:0] y,
                     input logic [15:0] exp);
    @(negedge clk);
    vif.i_x = x; vif.i_y = y; vif.i_hde = 1'b1; vif.i_vde = 1'b1;
    @(negedge clk);
    vif.i_hde = 1'b0; vif.i_vde = 1'b0;
    chk({tag, "_early_de"}, 32'(vif.o_de), 32'd0);
    @(negedge clk);
    chk({tag, "_de"}, 32'(vif.o_de), 32'd1);
    chk(tag, 32'(rgb()), 32'(exp));
    @(negedge clk);
    chk({tag, "_blank"}, {15'd0, vif.o_de, rgb()}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; next = 1'b0;
    vif.i_hsync = 1'b1; vif.i_vsync = 1'b1;
    vif.i_hde = 1'b0; vif.i_vde = 1'b0; vif.i_x = 9'd0; vif.i_y = 9'd0;
    repeat (2) @(negedge clk);
    chk("rst_de", 32'(vif.o_de), 32'd0);
    chk("rst_sync", {30'd0, vif.o_hsync, vif.o_vsync}, 32'd3);
    chk("rst_rgb", 32'(rgb()), 32'd0);
    chk("rst_pat_frame", {21'd0, pattern, frame}, 32'd0);
    rst = 1'b0;

    frame_start();
    chk("frame1", 32'(frame), 32'd1);
    chk("pat0", 32'(pattern), 32'd0);

    pix("bar_x0",   9'd0,   9'd10, c_white);
    pix("bar_x59",  9'd59,  9'd10, c_white);
    pix("bar_x60",  9'd60,  9'd10, c_yellow);
    pix("bar_x120", 9'd120, 9'd10, c_cyan);
    pix("bar_x239", 9'd239, 9'd10, c_green);
    pix("bar_x240", 9'd240, 9'd10, c_magenta);
    pix("bar_x300", 9'd300, 9'd10, c_red);
    pix("bar_x419", 9'd419, 9'd10, c_blue);
    pix("bar_x479", 9'd479, 9'd10, c_black);

    // hsync delay: low for one cycle, must appear exactly two cycles later
    @(negedge clk); vif.i_hsync = 1'b0;
    @(negedge clk); vif.i_hsync = 1'b1;
    chk("hsync_d1", 32'(vif.o_hsync), 32'd1);
    @(negedge clk);
    chk("hsync_d2", 32'(vif.o_hsync), 32'd0);
    @(negedge clk);
    chk("hsync_d3", 32'(vif.o_hsync), 32'd1);

    // DE with vde low must stay blank
    @(negedge clk); vif.i_hde = 1'b1; vif.i_vde = 1'b0; vif.i_x = 9'd5;
    @(negedge clk); vif.i_hde = 1'b0;
    @(negedge clk);
    chk("vde_low_blank", {15'd0, vif.o_de, rgb()}, 32'd0);

    pulse_next();
    chk("switch_hold", 32'(pattern), 32'd0);
    @(negedge clk); vif.i_vsync = 1'b0;
    chk("switch_pre_fs", 32'(pattern), 32'd0);
    @(negedge clk); vif.i_vsync = 1'b1;
    chk("switch_post_fs", 32'(pattern), 32'd1);
    pix("chk_0_0",   9'd0,  9'd0,  c_black);
    pix("chk_16_0",  9'd16, 9'd0,  c_white);
    pix("chk_16_16", 9'd16, 9'd16, c_black);

    @(negedge clk); vif.i_vsync = 1'b0; next = 1'b1;
    @(negedge clk); vif.i_vsync = 1'b1; next = 1'b0;
    chk("simul_fs", 32'(pattern), 32'd1);
    frame_start();
    chk("simul_next_fs", 32'(pattern), 32'd2);
    pix("hramp_200", 9'd200, 9'd7, {5'd12, 6'd25, 5'd12});

    pulse_next();
    frame_start();
    chk("pat3", 32'(pattern), 32'd3);
    pix("vramp_100", 9'd3, 9'd100, {5'd6, 6'd12, 5'd6});
    chk("frame5", 32'(frame), 32'd5);

    // Asynchronous reset while an active pixel is on the output
    @(negedge clk);
    vif.i_x = 9'd10; vif.i_y = 9'd10; vif.i_hde = 1'b1; vif.i_vde = 1'b1; vif.i_hsync = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_de", 32'(vif.o_de), 32'd1);
    rst = 1'b1;
    vif.i_hde = 1'b0; vif.i_vde = 1'b0; vif.i_hsync = 1'b1;
    #1;
    chk("arst_de", 32'(vif.o_de), 32'd0);
    chk("arst_sync", {30'd0, vif.o_hsync, vif.o_vsync}, 32'd3);
    chk("arst_rgb", 32'(rgb()), 32'd0);
    chk("arst_pat_frame", {21'd0, pattern, frame}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_blank", {15'd0, vif.o_de, rgb()}, 32'd0);
    frame_start();
    chk("post_rst_frame1", 32'(frame), 32'd1);

    repeat (4) pulse_next();
    frame_start();
    chk("pat4", 32'(pattern), 32'd4);
    repeat (237) frame_start();
    chk("frame239", 32'(frame), 32'd239);
    pix("bar478_x477", 9'd477, 9'd20, c_blue);
    pix("bar478_x478", 9'd478, 9'd20, c_white);
    pix("bar478_x479", 9'd479, 9'd20, c_white);
    frame_start();
    pix("bar0_x0",  9'd0,  9'd20, c_white);
    pix("bar0_x15", 9'd15, 9'd20, c_white);
    pix("bar0_x16", 9'd16, 9'd20, c_blue);

    pulse_next();
    frame_start();
    chk("pat5", 32'(pattern), 32'd5);
    pix("grid_0_5",     9'd0,   9'd5,   c_white);
    pix("grid_5_5",     9'd5,   9'd5,   c_black);
    pix("grid_479_100", 9'd479, 9'd100, c_white);
    pix("grid_100_271", 9'd100, 9'd271, c_white);
    pix("grid_100_270", 9'd100, 9'd270, c_black);
    pix("grid_5_32",    9'd5,   9'd32,  c_white);

    pulse_next();
    frame_start();
    pix("solid_white", 9'd123, 9'd45, c_white);
    pulse_next();
    frame_start();
    pix("solid_red", 9'd123, 9'd45, c_red);
    chk("frame243", 32'(frame), 32'd243);
    repeat (13) frame_start();
    chk("frame_wrap", 32'(frame), 32'd0);
    chk("pat7", 32'(pattern), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
